// File: rtl/data_memory_pipe.sv
// rtl/data_memory_pipe.sv - byte-addressable MEM-stage data memory with valid/ready handshake
// Loads/stores of 1..8 bytes, sign/zero extension, error detection and a debug word port.
module data_memory_pipe #(
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 64,
  parameter int ADDR_W      = 64,
  localparam int NWORDS     = DEPTH_BYTES * 8 / DATA_W,
  localparam int DBG_W      = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_error,
  output logic [7:0]        o_err_count,
  input  logic [DBG_W-1:0]  i_dbg_sel,
  output logic [DATA_W-1:0] o_dbg_word
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]        r_mem [DEPTH_BYTES];
  logic              r_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_error;
  logic [7:0]        r_err_count;

  logic              w_accept;
  logic [3:0]        w_n;
  logic [2:0]        w_mask;
  logic [ADDR_W:0]   w_end;
  logic              w_illegal, w_misaligned, w_range, w_err;
  logic [AW-1:0]     w_base;
  logic [DATA_W-1:0] w_raw, w_load, w_dbg;
  logic              w_sign, w_ext;

  assign o_req_ready = !r_valid || i_rsp_ready;
  assign w_accept    = i_req_valid && o_req_ready;

  assign w_n          = 4'd1 << i_req_size;
  assign w_mask       = 3'(w_n - 4'd1);
  assign w_illegal    = int'(w_n) > NB;
  assign w_misaligned = |(i_req_addr[2:0] & w_mask);
  // Full-width sum so addresses near the top of the address space cannot wrap into range.
  assign w_end        = {1'b0, i_req_addr} + (ADDR_W+1)'(w_n);
  assign w_range      = w_end > (ADDR_W+1)'(DEPTH_BYTES);
  assign w_err        = w_illegal || w_misaligned || w_range;
  assign w_base       = i_req_addr[AW-1:0];

  always_comb begin
    w_raw  = '0;
    w_sign = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(w_n)) begin
        w_raw[8*i +: 8] = r_mem[w_base + AW'(i)];
        if (i == int'(w_n) - 1) w_sign = w_raw[8*i+7];
      end
    end
    w_ext  = !i_req_unsigned && w_sign && (int'(w_n) < NB);
    w_load = '0;
    for (int i = 0; i < NB; i++) begin
      w_load[8*i +: 8] = (i < int'(w_n)) ? w_raw[8*i +: 8] : {8{w_ext}};
    end
  end

  always_comb begin
    w_dbg = '0;
    for (int i = 0; i < NB; i++) begin
      w_dbg[8*i +: 8] = r_mem[AW'(int'(i_dbg_sel) * NB + i)];
    end
  end
  assign o_dbg_word = w_dbg;

  // Stores commit on the acceptance edge, so a load accepted next cycle sees them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < DEPTH_BYTES; k++) begin
        r_mem[k] <= ((k % 8 == 0) && (k / 8 < DEPTH_BYTES / 8)) ? 8'(k / 8 + 1) : 8'h00;
      end
    end else if (w_accept && i_req_write && !w_err) begin
      for (int i = 0; i < NB; i++) begin
        if (i < int'(w_n)) r_mem[w_base + AW'(i)] <= i_req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid     <= 1'b0;
      r_rdata     <= '0;
      r_error     <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_error <= w_err;
        r_rdata <= (w_err || i_req_write) ? '0 : w_load;
        if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end else if (i_rsp_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_rsp_valid = r_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_error = r_error;
  assign o_err_count = r_err_count;
endmodule
